// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit direction counters, registered
// lookup, write-first bypass from the resolve-stage update port.
module branch_predictor #(
    parameter int PC_WIDTH   = 32,
    parameter int INDEX_BITS = 6,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 lookup_valid,
    input  logic [PC_WIDTH-1:0]  lookup_pc,
    input  logic                 flush,
    input  logic                 update_valid,
    input  logic [PC_WIDTH-1:0]  update_pc,
    input  logic                 update_taken,
    input  logic [PC_WIDTH-1:0]  update_target,
    input  logic                 update_mispredict,
    output logic                 pred_valid,
    output logic                 pred_taken,
    output logic [PC_WIDTH-1:0]  pred_target,
    output logic                 pred_hit,
    output logic [CNT_WIDTH-1:0] mispredict_count
);
    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = PC_WIDTH - INDEX_BITS - 2;

    logic                valid_q  [ENTRIES];
    logic [1:0]          cnt_q    [ENTRIES];
    logic [TAG_W-1:0]    tag_q    [ENTRIES];
    logic [PC_WIDTH-1:0] target_q [ENTRIES];

    logic                 pred_valid_q, pred_taken_q, pred_hit_q;
    logic [PC_WIDTH-1:0]  pred_target_q;
    logic [CNT_WIDTH-1:0] mis_cnt_q, mis_cnt_d;

    logic [INDEX_BITS-1:0] u_idx, l_idx;
    logic [TAG_W-1:0]      u_tag, l_tag;
    logic                  u_hit, u_we;
    logic [1:0]            u_cnt_d;
    logic [PC_WIDTH-1:0]   u_target_d;

    logic                byp, e_valid, l_hit, l_taken;
    logic [TAG_W-1:0]    e_tag;
    logic [1:0]          e_cnt;
    logic [PC_WIDTH-1:0] e_target, l_target;
    logic                unused_pc_lsbs;

    assign unused_pc_lsbs = ^update_pc[1:0];

    always_comb begin
        u_idx      = update_pc[INDEX_BITS+1:2];
        u_tag      = update_pc[PC_WIDTH-1:INDEX_BITS+2];
        u_hit      = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
        u_we       = update_valid && (u_hit || update_taken);
        u_cnt_d    = !u_hit ? 2'd2 :
                     update_taken ? ((cnt_q[u_idx] == 2'd3) ? 2'd3 : cnt_q[u_idx] + 2'd1) :
                     ((cnt_q[u_idx] == 2'd0) ? 2'd0 : cnt_q[u_idx] - 2'd1);
        u_target_d = update_taken ? update_target : target_q[u_idx];
        mis_cnt_d  = (update_valid && update_mispredict && !(&mis_cnt_q)) ?
                     mis_cnt_q + CNT_WIDTH'(1) : mis_cnt_q;
    end

    // Lookup sees the entry as it will be after this cycle's update.
    always_comb begin
        l_idx    = lookup_pc[INDEX_BITS+1:2];
        l_tag    = lookup_pc[PC_WIDTH-1:INDEX_BITS+2];
        byp      = u_we && (u_idx == l_idx);
        e_valid  = byp || valid_q[l_idx];
        e_tag    = byp ? u_tag : tag_q[l_idx];
        e_cnt    = byp ? u_cnt_d : cnt_q[l_idx];
        e_target = byp ? u_target_d : target_q[l_idx];
        l_hit    = e_valid && (e_tag == l_tag);
        l_taken  = l_hit && e_cnt[1];
        l_target = l_taken ? e_target : lookup_pc + PC_WIDTH'(4);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i] <= 1'b0;
                cnt_q[i]   <= 2'd1;
            end
            pred_valid_q  <= 1'b0;
            pred_taken_q  <= 1'b0;
            pred_hit_q    <= 1'b0;
            pred_target_q <= '0;
            mis_cnt_q     <= '0;
        end else begin
            if (u_we) begin
                valid_q[u_idx] <= 1'b1;
                cnt_q[u_idx]   <= u_cnt_d;
            end
            pred_valid_q <= lookup_valid && !flush;
            if (lookup_valid && !flush) begin
                pred_taken_q  <= l_taken;
                pred_hit_q    <= l_hit;
                pred_target_q <= l_target;
            end
            mis_cnt_q <= mis_cnt_d;
        end
    end

    // Tag and target are qualified by valid_q, so they need no reset.
    always_ff @(posedge clk) begin
        if (u_we) begin
            tag_q[u_idx]    <= u_tag;
            target_q[u_idx] <= u_target_d;
        end
    end

    assign pred_valid       = pred_valid_q;
    assign pred_taken       = pred_taken_q;
    assign pred_hit         = pred_hit_q;
    assign pred_target      = pred_target_q;
    assign mispredict_count = mis_cnt_q;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed stimulus with a queue scoreboard; a negedge
// monitor pops expected predictions whenever pred_valid is seen.
module tb_branch_predictor;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        lookup_valid = 1'b0, flush = 1'b0;
    logic [31:0] lookup_pc = '0;
    logic        update_valid = 1'b0, update_taken = 1'b0, update_mispredict = 1'b0;
    logic [31:0] update_pc = '0, update_target = '0;
    logic        pred_valid, pred_taken, pred_hit;
    logic [31:0] pred_target;
    logic [3:0]  mispredict_count;

    int checks = 0;
    int failures = 0;
    int lk_id = 0;

    typedef struct {
        int          id;
        logic        hit;
        logic        taken;
        logic [31:0] target;
    } exp_t;
    exp_t q[$];
    exp_t mon_e;

    branch_predictor #(.PC_WIDTH(32), .INDEX_BITS(6), .CNT_WIDTH(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .flush(flush),
        .update_valid(update_valid), .update_pc(update_pc), .update_taken(update_taken),
        .update_target(update_target), .update_mispredict(update_mispredict),
        .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
        .pred_hit(pred_hit), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset_n && pred_valid) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pred_valid got=1 want=0 at %0t", $time);
            end else begin
                mon_e = q.pop_front();
                if ({pred_hit, pred_taken, pred_target} !== {mon_e.hit, mon_e.taken, mon_e.target}) begin
                    failures++;
                    $display("FAIL lookup%0d got hit=%0b taken=%0b target=%h want hit=%0b taken=%0b target=%h",
                             mon_e.id, pred_hit, pred_taken, pred_target, mon_e.hit, mon_e.taken, mon_e.target);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        lookup_valid = 1'b0;
        flush = 1'b0;
        update_valid = 1'b0;
        update_mispredict = 1'b0;
    endtask

    task automatic set_lookup(input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tgt);
        lookup_valid = 1'b1;
        lookup_pc = pc;
        q.push_back('{lk_id, h, t, tgt});
        lk_id++;
    endtask

    task automatic set_update(input logic [31:0] pc, input logic t, input logic [31:0] tgt, input logic m);
        update_valid = 1'b1;
        update_pc = pc;
        update_taken = t;
        update_target = tgt;
        update_mispredict = m;
    endtask

    task automatic lookup(input logic [31:0] pc, input logic h, input logic t, input logic [31:0] tgt);
        set_lookup(pc, h, t, tgt);
        tick();
    endtask

    task automatic update(input logic [31:0] pc, input logic t, input logic [31:0] tgt);
        set_update(pc, t, tgt, 1'b0);
        tick();
    endtask

    initial begin
        #12;
        chk("reset_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("reset_pred_hit", {31'd0, pred_hit}, 32'd0);
        chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("reset_pred_target", pred_target, 32'h0);
        chk("reset_mcount", {28'd0, mispredict_count}, 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        tick();

        lookup(32'h100, 0, 0, 32'h104);
        update(32'h100, 1, 32'h200);
        lookup(32'h100, 1, 1, 32'h200);
        update(32'h100, 0, 32'h0);
        lookup(32'h100, 1, 0, 32'h104);
        update(32'h100, 0, 32'h0);
        lookup(32'h100, 1, 0, 32'h104);
        repeat (3) update(32'h100, 0, 32'h0);
        lookup(32'h100, 1, 0, 32'h104);
        update(32'h100, 1, 32'h250);
        lookup(32'h100, 1, 0, 32'h104);
        update(32'h100, 1, 32'h250);
        lookup(32'h100, 1, 1, 32'h250);

        update(32'h200, 1, 32'h500);
        lookup(32'h100, 0, 0, 32'h104);
        lookup(32'h200, 1, 1, 32'h500);

        set_update(32'h300, 1, 32'h400, 0); set_lookup(32'h300, 1, 1, 32'h400); tick();
        set_update(32'h300, 0, 32'h0, 0);   set_lookup(32'h300, 1, 0, 32'h304); tick();
        set_update(32'h700, 1, 32'h800, 0); set_lookup(32'h300, 0, 0, 32'h304); tick();
        set_update(32'h104, 1, 32'h900, 0); set_lookup(32'h700, 1, 1, 32'h800); tick();
        lookup(32'h104, 1, 1, 32'h900);

        lookup_valid = 1'b1; lookup_pc = 32'h104; flush = 1'b1;
        set_update(32'h108, 1, 32'ha00, 0);
        tick();
        @(negedge clk);
        chk("flush_pred_valid", {31'd0, pred_valid}, 32'd0);
        chk("flush_hold_target", pred_target, 32'h900);
        #1;
        lookup(32'h108, 1, 1, 32'ha00);
        lookup(32'hffff_fffc, 0, 0, 32'h0000_0000);

        update_mispredict = 1'b1;
        tick();
        @(negedge clk);
        chk("mcount_ignored", {28'd0, mispredict_count}, 32'd0);
        #1;
        repeat (3) begin set_update(32'h1000, 0, 32'h0, 1); tick(); end
        @(negedge clk);
        chk("mcount_3", {28'd0, mispredict_count}, 32'd3);
        #1;
        repeat (17) begin set_update(32'h1000, 0, 32'h0, 1); tick(); end
        @(negedge clk);
        chk("mcount_sat", {28'd0, mispredict_count}, 32'd15);

        #3;
        reset_n = 1'b0;
        #1;
        chk("midreset_mcount", {28'd0, mispredict_count}, 32'd0);
        chk("midreset_pred_target", pred_target, 32'h0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        lookup(32'h104, 0, 0, 32'h108);
        lookup(32'h108, 0, 0, 32'h10c);
        lookup(32'h700, 0, 0, 32'h704);
        repeat (3) tick();
        chk("scoreboard_drained", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end
endmodule
